dec_lut_result_collector: RTL and testbench
===========================================

// Module: dec_lut_result_collector
// PURPOSE
//   Downstream stage of the 52-bit clocked LUT decoder. Watches the decoder's level-held found/N
//   outputs after each new W is applied, captures one result per request, checks N against the
//   expected all-ones value, and queues {N, match, timeout} in a 4-deep FIFO behind a valid/ready
//   port. Keeps saturating total/error counters for on-chip self-check; replaces bench-side polling.
// PARAMETERS
//   N_BITS      53                     width of decoder N bus
//   EXP_N       53'h0F_FFFF_FFFF_FFFF  expected N (52 ones, MSB 0)
//   SETTLE_CYC  2                      cycles after arm during which found_i is ignored (stale found)
//   TIMEOUT_CYC 1024                   cycles after settle with no found -> timeout entry
//   DEPTH       4                      result FIFO depth (power of 2)
//   CNT_W       16                     counter width
// PORTS
//   clk          in   1       clock, all state on rising edge
//   rst          in   1       asynchronous reset, active-high
//   arm          in   1       1-cycle pulse: new W has just been driven into the decoder
//   found_i      in   1       decoder found (level)
//   n_i          in   N_BITS  decoder N
//   out_valid    out  1       FIFO head valid
//   out_ready    in   1       consumer accepts head when out_valid&out_ready
//   out_n        out  N_BITS  head N (0 for timeout entries)
//   out_match    out  1       head: n == EXP_N and not timeout
//   out_timeout  out  1       head: request timed out
//   busy         out  1       request in flight (state != IDLE)
//   overflow     out  1       sticky: result dropped because FIFO full
//   total_cnt    out  CNT_W   requests completed (captured or timed out), saturating
//   err_cnt      out  CNT_W   mismatches + timeouts, saturating
// BEHAVIOUR
//   Reset (async, rst=1): state IDLE, FIFO empty, all outputs 0, counters 0, overflow 0.
//   FSM: IDLE -arm-> SETTLE; SETTLE: count SETTLE_CYC cycles, found_i ignored -> WAIT;
//     WAIT: found_i==1 -> capture n_i, push {n_i, n_i==EXP_N, 0}, -> IDLE;
//           timer hits TIMEOUT_CYC-1 with found_i==0 -> push {0, 0, 1}, -> IDLE.
//   arm in SETTLE/WAIT: current request aborted (no push, not counted), restart SETTLE.
//   arm in same cycle as a WAIT capture/timeout: the completing result is pushed, new SETTLE begins.
//   Latency: found_i sampled high in WAIT -> out_valid high next cycle (if FIFO was empty).
//   Completion: total_cnt += 1; err_cnt += 1 if !match; both saturate at all-ones, never wrap.
//   FIFO: push and pop same cycle allowed in any fill state incl. full (pop frees slot, push kept);
//     push when full with no pop: entry dropped, overflow<=1 (cleared only by rst), counters still update.
//   out_* are registered FIFO-head fields; stable while out_valid & !out_ready.
//   Pointers: log2(DEPTH)+1 bits, wrap naturally; full = MSB differ, rest equal.
//   Compare is exact N_BITS-wide equality; X/Z never expected on n_i when found_i=1.
// STRUCTURE
//   Package dec_lut_pkg: N_BITS, EXP_N, state enum {IDLE,SETTLE,WAIT}, result struct {n,match,timeout}.
//   Sub-module dec_lut_res_fifo (sync FIFO, DEPTH x result struct, full/empty, async active-high rst).
//   Top: FSM + settle/timeout counter (shared, clog2(max) bits) + compare + saturating counters.
// TESTING
//   1 arm; found_i=1 with n_i=EXP_N 5 cycles later -> one entry n=EXP_N, match=1; total=1, err=0.
//   2 arm; found_i held 1 from prior request, n_i=5 during SETTLE, new n_i=EXP_N at cycle 3 -> entry
//     EXP_N match=1 (stale value not captured).
//   3 arm; found_i=1 with n_i=EXP_N-1 -> match=0, err_cnt=1; arm, no found for 1024+2 cycles ->
//     entry n=0 timeout=1, err_cnt=2, total_cnt=2.
//   4 out_ready=0, complete 5 requests -> 4 entries kept, overflow=1, total=5; then drain in order,
//     out_valid drops after 4th pop; full + push + pop same cycle keeps count at 4.
//   5 arm at cycle 10 of WAIT -> old request aborted, no entry; rst asserted mid-WAIT -> all outputs
//     0 immediately (async), FIFO empty, busy=0.
//   6 force total_cnt/err_cnt near 16'hFFFF via 65536+ failing requests (or short CNT_W=4 build) -> hold at max.

Source files
------------

// File: rtl/dec_lut_pkg.sv
// Shared types and constants for the LUT-decoder result collector.
package dec_lut_pkg;

  localparam int unsigned N_BITS = 53;
  // 52 ones with the MSB clear: the N every correct decode must produce.
  localparam logic [N_BITS-1:0] EXP_N = 53'h0F_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StWait
  } state_e;

  typedef struct packed {
    logic [N_BITS-1:0] n;
    logic              match;
    logic              timeout;
  } result_t;

endpackage

// File: rtl/dec_lut_res_fifo.sv
// Synchronous result FIFO; push and pop may coincide in any fill state, including full.
module dec_lut_res_fifo
  import dec_lut_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  result_t wdata,
  input  logic    pop,
  output result_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  result_t       mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  // Full/empty from extra-MSB pointers; a pop frees the slot for a same-cycle push.
  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || pop);
    rdata   = empty ? '0 : mem[rptr[AW-1:0]];
  end

  // Storage and pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/dec_lut_result_collector.sv
// Watches decoder found/N after each arm, captures one result per request and queues it.
module dec_lut_result_collector
  import dec_lut_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              found_i,
  input  logic [N_BITS-1:0] n_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_n,
  output logic              out_match,
  output logic              out_timeout,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  total_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             push;
  result_t          wres;
  result_t          head;
  logic             full;
  logic             empty;

  // Next state, shared settle/timeout timer and the result to push.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    push    = 1'b0;
    wres    = '0;
    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d = StSettle;
          tmr_d   = '0;
        end
      end
      StSettle: begin
        // found_i may still reflect the previous W here, so it is ignored.
        if (arm) begin
          tmr_d = '0;
        end else if (tmr_q == SETTLE_LAST) begin
          state_d = StWait;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StWait: begin
        if (found_i) begin
          push       = 1'b1;
          wres.n     = n_i;
          wres.match = (n_i == EXP_N);
          state_d    = StIdle;
        end else if (tmr_q == TMO_LAST) begin
          push         = 1'b1;
          wres.timeout = 1'b1;
          state_d      = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
        // A new arm restarts settling; a result completing this cycle is still pushed.
        if (arm) begin
          state_d = StSettle;
          tmr_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Saturating completion/error counters and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_cnt <= '0;
      err_cnt   <= '0;
      overflow  <= 1'b0;
    end else if (push) begin
      if (total_cnt != '1) total_cnt <= total_cnt + 1'b1;
      if (!wres.match && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      if (full && !out_ready) overflow <= 1'b1;
    end
  end

  dec_lut_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wres),
    .pop   (out_ready),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Head fields come straight from FIFO registers.
  always_comb begin
    out_valid   = !empty;
    out_n       = head.n;
    out_match   = head.match;
    out_timeout = head.timeout;
    busy        = (state_q != StIdle);
  end

endmodule

// File: tb/tb_dec_lut_result_collector.sv
// Directed self-checking bench for dec_lut_result_collector (short CNT_W to reach saturation).
module tb_dec_lut_result_collector;
  import dec_lut_pkg::*;

  localparam int unsigned CW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              arm = 1'b0;
  logic              found_i = 1'b0;
  logic [N_BITS-1:0] n_i = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N_BITS-1:0] out_n;
  logic              out_match;
  logic              out_timeout;
  logic              busy;
  logic              overflow;
  logic [CW-1:0]     total_cnt;
  logic [CW-1:0]     err_cnt;

  int errs   = 0;
  int checks = 0;

  dec_lut_result_collector #(
    .SETTLE_CYC  (2),
    .TIMEOUT_CYC (1024),
    .DEPTH       (4),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .found_i     (found_i),
    .n_i         (n_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_n       (out_n),
    .out_match   (out_match),
    .out_timeout (out_timeout),
    .busy        (busy),
    .overflow    (overflow),
    .total_cnt   (total_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  // arm, two settle edges, then found with value v on the first WAIT edge.
  task automatic quick_req(input logic [N_BITS-1:0] v);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    found_i = 1'b1;
    n_i     = v;
    tick();
    found_i = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [N_BITS-1:0] exp_q [4];

  initial begin
    // Reset state
    rst = 1'b1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_total", 64'(total_cnt), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_n", 64'(out_n), 64'd0);
    rst = 1'b0;
    tick();

    // 1: found with EXP_N five cycles after arm
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_no_entry", 64'(out_valid), 64'd0);
    found_i = 1'b1;
    n_i     = EXP_N;
    tick();
    found_i = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_n", 64'(out_n), 64'(EXP_N));
    chk("t1_match", 64'(out_match), 64'd1);
    chk("t1_tmo", 64'(out_timeout), 64'd0);
    chk("t1_total", 64'(total_cnt), 64'd1);
    chk("t1_err", 64'(err_cnt), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);
    tick();
    chk("t1_hold", 64'(out_n), 64'(EXP_N));
    pop_one();
    chk("t1_popped", 64'(out_valid), 64'd0);

    // 2: stale found during settle must not be captured
    found_i = 1'b1;
    n_i     = 53'd5;
    arm     = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    chk("t2_no_stale", 64'(out_valid), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    n_i = EXP_N;
    tick();
    found_i = 1'b0;
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_n", 64'(out_n), 64'(EXP_N));
    chk("t2_match", 64'(out_match), 64'd1);
    chk("t2_total", 64'(total_cnt), 64'd2);
    pop_one();

    // 3: mismatch, then timeout
    do_reset();
    quick_req(EXP_N - 1);
    chk("t3_n", 64'(out_n), 64'(EXP_N - 1));
    chk("t3_match", 64'(out_match), 64'd0);
    chk("t3_err", 64'(err_cnt), 64'd1);
    pop_one();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 1025; i++) tick();
    chk("t3_pre_tmo", 64'(out_valid), 64'd0);
    chk("t3_pre_busy", 64'(busy), 64'd1);
    tick();
    chk("t3_tmo_valid", 64'(out_valid), 64'd1);
    chk("t3_tmo", 64'(out_timeout), 64'd1);
    chk("t3_tmo_n", 64'(out_n), 64'd0);
    chk("t3_tmo_match", 64'(out_match), 64'd0);
    chk("t3_err2", 64'(err_cnt), 64'd2);
    chk("t3_total2", 64'(total_cnt), 64'd2);
    chk("t3_idle", 64'(busy), 64'd0);
    pop_one();

    // 4: overflow with 5 results, drain in order
    do_reset();
    exp_q[0] = EXP_N;
    exp_q[1] = 53'd2;
    exp_q[2] = 53'd3;
    exp_q[3] = 53'd4;
    for (int i = 0; i < 4; i++) quick_req(exp_q[i]);
    chk("t4_no_ovf", 64'(overflow), 64'd0);
    quick_req(53'd5);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_total", 64'(total_cnt), 64'd5);
    chk("t4_err", 64'(err_cnt), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_drain%0d_v", i), 64'(out_valid), 64'd1);
      chk($sformatf("t4_drain%0d_n", i), 64'(out_n), 64'(exp_q[i]));
      pop_one();
    end
    chk("t4_empty", 64'(out_valid), 64'd0);

    // 4b: full + push + pop in the same cycle keeps 4 entries, no overflow
    do_reset();
    for (int i = 0; i < 4; i++) quick_req(53'(10 + i));
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    found_i   = 1'b1;
    n_i       = 53'd14;
    out_ready = 1'b1;
    tick();
    found_i   = 1'b0;
    out_ready = 1'b0;
    chk("t4b_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4b_drain%0d_n", i), 64'(out_n), 64'(11 + i));
      pop_one();
    end
    chk("t4b_empty", 64'(out_valid), 64'd0);

    // 5: arm mid-WAIT aborts; arm with completion pushes and restarts; async reset
    do_reset();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("t5_abort_v", 64'(out_valid), 64'd0);
    chk("t5_abort_tot", 64'(total_cnt), 64'd0);
    chk("t5_abort_busy", 64'(busy), 64'd1);
    tick();
    tick();
    found_i = 1'b1;
    n_i     = EXP_N;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
    found_i = 1'b0;
    chk("t5_arm_cap_v", 64'(out_valid), 64'd1);
    chk("t5_arm_cap_busy", 64'(busy), 64'd1);
    chk("t5_arm_cap_tot", 64'(total_cnt), 64'd1);
    tick();
    tick();
    found_i = 1'b1;
    n_i     = 53'd7;
    tick();
    found_i = 1'b0;
    chk("t5_second_tot", 64'(total_cnt), 64'd2);
    chk("t5_second_err", 64'(err_cnt), 64'd1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    chk("t5_arst_v", 64'(out_valid), 64'd0);
    chk("t5_arst_busy", 64'(busy), 64'd0);
    chk("t5_arst_tot", 64'(total_cnt), 64'd0);
    chk("t5_arst_err", 64'(err_cnt), 64'd0);
    chk("t5_arst_n", 64'(out_n), 64'd0);
    rst = 1'b0;
    tick();

    // 6: counters saturate at all-ones
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) quick_req(53'd0);
    chk("t6_tot15", 64'(total_cnt), 64'd15);
    chk("t6_err15", 64'(err_cnt), 64'd15);
    quick_req(53'd0);
    quick_req(53'd0);
    quick_req(EXP_N);
    chk("t6_tot_sat", 64'(total_cnt), 64'd15);
    chk("t6_err_sat", 64'(err_cnt), 64'd15);
    out_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
